// File: rtl/exe_stage_bju_pkg.sv
// Shared definitions for the EXE-stage branch/jump unit: condition-bus layout,
// FSM state encodings and the target-alignment mask helper.
package exe_stage_bju_pkg;

    localparam int BJ_BUS  = 8;
    localparam int BJ_BEQ  = 0;
    localparam int BJ_BNE  = 1;
    localparam int BJ_BLT  = 2;
    localparam int BJ_BGE  = 3;
    localparam int BJ_BLTU = 4;
    localparam int BJ_BGEU = 5;
    localparam int BJ_JALR = 6;
    localparam int BJ_JAL  = 7;

    typedef enum logic [1:0] {
        BJU_IDLE  = 2'd0,
        BJU_REQ   = 2'd1,
        BJU_FLUSH = 2'd2
    } bju_state_e;

    // Bit 0 is never checked: it is cleared for JALR and always 0 for pc+imm.
    function automatic logic [63:0] align_mask(input int unsigned align_lg);
        logic [63:0] m;
        m = (64'd1 << align_lg) - 64'd1;
        return m & ~64'h1;
    endfunction

endpackage

// File: rtl/exe_stage_bju_counter.sv
// 64-bit enable-increment statistics counter; wraps silently at 2^64.
module bju_counter64 (
    input  logic        clk,
    input  logic        rst,
    input  logic        en_i,
    output logic [63:0] cnt_o
);

    logic [63:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 64'd0;
        end else if (en_i) begin
            cnt_q <= cnt_q + 64'd1;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/exe_stage_bju.sv
// EXE-stage branch/jump resolution: decides taken, computes the target, holds a
// redirect to IF until accepted, then pulses a one-cycle flush of IF/ID.
module exe_stage_bju
    import exe_stage_bju_pkg::*;
#(
    parameter int unsigned RESET_PC_ALIGN = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [63:0]       pc,
    input  logic [63:0]       imm,
    input  logic [63:0]       op1,
    input  logic [BJ_BUS-1:0] bj_info,
    input  logic [BJ_BUS-1:0] bj_data,
    output logic              link_valid,
    output logic [63:0]       link_data,
    output logic              redirect_valid,
    output logic [63:0]       redirect_pc,
    input  logic              redirect_ready,
    output logic              flush,
    output logic              exc_misalign,
    output logic [63:0]       exc_tval,
    output logic [63:0]       cnt_branch,
    output logic [63:0]       cnt_taken
);

    localparam logic [63:0] ALIGN_MASK = align_mask(RESET_PC_ALIGN);

    bju_state_e  state_q;
    logic        link_valid_q;
    logic [63:0] link_data_q;
    logic        redirect_valid_q;
    logic [63:0] redirect_pc_q;
    logic        flush_q;
    logic        exc_misalign_q;
    logic [63:0] exc_tval_q;

    logic        accept;
    logic        taken;
    logic        misalign;
    logic [63:0] target;

    // in_ready depends on state only, so the stall never loops back through EXE.
    assign in_ready = (state_q == BJU_IDLE);
    assign accept   = in_valid & in_ready & (|bj_info);
    assign taken    = |(bj_info & bj_data);
    assign target   = bj_info[BJ_JALR] ? ((op1 + imm) & ~64'h1) : (pc + imm);
    assign misalign = |(target & ALIGN_MASK);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= BJU_IDLE;
            link_valid_q     <= 1'b0;
            link_data_q      <= 64'd0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= 64'd0;
            flush_q          <= 1'b0;
            exc_misalign_q   <= 1'b0;
            exc_tval_q       <= 64'd0;
        end else begin
            link_valid_q   <= 1'b0;
            exc_misalign_q <= 1'b0;
            flush_q        <= 1'b0;
            case (state_q)
                BJU_IDLE: begin
                    if (accept) begin
                        link_valid_q <= 1'b1;
                        link_data_q  <= pc + 64'd4;
                        if (taken && misalign) begin
                            // Trap path owns the flush; no redirect here.
                            exc_misalign_q <= 1'b1;
                            exc_tval_q     <= target;
                        end else if (taken) begin
                            state_q          <= BJU_REQ;
                            redirect_valid_q <= 1'b1;
                            redirect_pc_q    <= target;
                        end
                    end
                end
                BJU_REQ: begin
                    if (redirect_ready) begin
                        state_q          <= BJU_FLUSH;
                        redirect_valid_q <= 1'b0;
                        flush_q          <= 1'b1;
                    end
                end
                BJU_FLUSH: begin
                    state_q <= BJU_IDLE;
                end
                default: begin
                    state_q          <= BJU_IDLE;
                    redirect_valid_q <= 1'b0;
                end
            endcase
        end
    end

    bju_counter64 u_cnt_branch (
        .clk   (clk),
        .rst   (rst),
        .en_i  (accept),
        .cnt_o (cnt_branch)
    );

    bju_counter64 u_cnt_taken (
        .clk   (clk),
        .rst   (rst),
        .en_i  (accept & taken),
        .cnt_o (cnt_taken)
    );

    assign link_valid     = link_valid_q;
    assign link_data      = link_data_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign flush          = flush_q;
    assign exc_misalign   = exc_misalign_q;
    assign exc_tval       = exc_tval_q;

endmodule

// File: tb/tb_exe_stage_bju.sv
// Directed bench for exe_stage_bju: hand-computed vectors checked with
// immediate assertions one cycle step at a time.
module tb_exe_stage_bju;
    import exe_stage_bju_pkg::*;

    localparam logic [7:0] I_BEQ  = 8'(1 << BJ_BEQ);
    localparam logic [7:0] I_BNE  = 8'(1 << BJ_BNE);
    localparam logic [7:0] I_JALR = 8'(1 << BJ_JALR);
    localparam logic [7:0] I_JAL  = 8'(1 << BJ_JAL);
    localparam logic [7:0] D_JMP  = I_JALR | I_JAL;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] pc;
    logic [63:0] imm;
    logic [63:0] op1;
    logic [7:0]  bj_info;
    logic [7:0]  bj_data;
    logic        link_valid;
    logic [63:0] link_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        redirect_ready;
    logic        flush;
    logic        exc_misalign;
    logic [63:0] exc_tval;
    logic [63:0] cnt_branch;
    logic [63:0] cnt_taken;

    int n_checks;
    int n_fail;
    int flushes;

    exe_stage_bju dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .pc             (pc),
        .imm            (imm),
        .op1            (op1),
        .bj_info        (bj_info),
        .bj_data        (bj_data),
        .link_valid     (link_valid),
        .link_data      (link_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .redirect_ready (redirect_ready),
        .flush          (flush),
        .exc_misalign   (exc_misalign),
        .exc_tval       (exc_tval),
        .cnt_branch     (cnt_branch),
        .cnt_taken      (cnt_taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] info, input logic [7:0] data,
                         input logic [63:0] p, input logic [63:0] im, input logic [63:0] o1);
        in_valid = 1'b1;
        bj_info  = info;
        bj_data  = data;
        pc       = p;
        imm      = im;
        op1      = o1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        bj_info  = 8'h00;
        bj_data  = 8'h00;
        pc       = 64'd0;
        imm      = 64'd0;
        op1      = 64'd0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        flushes  = 0;
        rst = 1'b1;
        redirect_ready = 1'b0;
        idle();

        // Reset values while reset is held
        #12;
        chkb("rst_in_ready", in_ready, 1'b1);
        chkb("rst_redirect_valid", redirect_valid, 1'b0);
        chkb("rst_link_valid", link_valid, 1'b0);
        chkb("rst_flush", flush, 1'b0);
        chkb("rst_exc", exc_misalign, 1'b0);
        chk("rst_cnt_branch", cnt_branch, 64'd0);
        chk("rst_cnt_taken", cnt_taken, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chkb("post_rst_in_ready", in_ready, 1'b1);

        // BEQ taken, IF always ready
        redirect_ready = 1'b1;
        drive(I_BEQ, I_BEQ | D_JMP, 64'h8000_0000, 64'h40, 64'h0);
        tick();
        idle();
        chkb("beq_rv_n1", redirect_valid, 1'b1);
        chk("beq_rpc_n1", redirect_pc, 64'h8000_0040);
        chkb("beq_in_ready_n1", in_ready, 1'b0);
        chkb("beq_flush_n1", flush, 1'b0);
        chkb("beq_link_valid", link_valid, 1'b1);
        chk("beq_link_data", link_data, 64'h8000_0004);
        chk("beq_cnt_branch", cnt_branch, 64'd1);
        chk("beq_cnt_taken", cnt_taken, 64'd1);
        tick();
        chkb("beq_flush_n2", flush, 1'b1);
        chkb("beq_rv_n2", redirect_valid, 1'b0);
        chkb("beq_in_ready_n2", in_ready, 1'b0);
        tick();
        chkb("beq_in_ready_n3", in_ready, 1'b1);
        chkb("beq_flush_n3", flush, 1'b0);

        // BNE not taken, four back-to-back accepts
        for (int i = 0; i < 4; i++) begin
            drive(I_BNE, D_JMP, 64'h100 + 64'(4 * i), 64'h20, 64'h0);
            chkb("bne_in_ready", in_ready, 1'b1);
            tick();
            chkb("bne_link_valid", link_valid, 1'b1);
            chk("bne_link_data", link_data, 64'h104 + 64'(4 * i));
            chkb("bne_rv", redirect_valid, 1'b0);
            chkb("bne_flush", flush, 1'b0);
        end
        idle();
        chk("bne_cnt_branch", cnt_branch, 64'd5);
        chk("bne_cnt_taken", cnt_taken, 64'd1);
        tick();
        chkb("bne_link_valid_drop", link_valid, 1'b0);

        // JALR to a target with bit 1 set
        drive(I_JALR, D_JMP, 64'h200, 64'h0, 64'h8000_1003);
        tick();
        idle();
        chkb("jalr_mis_exc", exc_misalign, 1'b1);
        chk("jalr_mis_tval", exc_tval, 64'h8000_1002);
        chkb("jalr_mis_rv", redirect_valid, 1'b0);
        chkb("jalr_mis_in_ready", in_ready, 1'b1);
        chk("jalr_mis_link", link_data, 64'h204);
        chk("jalr_mis_cnt_branch", cnt_branch, 64'd6);
        chk("jalr_mis_cnt_taken", cnt_taken, 64'd2);
        tick();
        chkb("jalr_mis_exc_drop", exc_misalign, 1'b0);
        chkb("jalr_mis_no_flush", flush, 1'b0);
        chkb("jalr_mis_no_rv", redirect_valid, 1'b0);

        // JALR aligned: bit 0 of the sum is cleared
        drive(I_JALR, D_JMP, 64'h300, 64'h10, 64'h8000_2001);
        tick();
        idle();
        chkb("jalr_rv", redirect_valid, 1'b1);
        chk("jalr_rpc", redirect_pc, 64'h8000_2010);
        chkb("jalr_no_exc", exc_misalign, 1'b0);
        tick();
        chkb("jalr_flush", flush, 1'b1);
        tick();
        chkb("jalr_in_ready", in_ready, 1'b1);

        // JAL with IF stalling five cycles, competing in_valid during the wait
        redirect_ready = 1'b0;
        drive(I_JAL, D_JMP, 64'h3000, 64'hFFFF_FFFF_FFFF_FF00, 64'h0);
        tick();
        for (int k = 1; k <= 6; k++) begin
            chkb("jal_wait_rv", redirect_valid, 1'b1);
            chk("jal_wait_rpc", redirect_pc, 64'h2F00);
            chkb("jal_wait_in_ready", in_ready, 1'b0);
            chk("jal_wait_link", link_data, 64'h3004);
            chk("jal_wait_cnt_branch", cnt_branch, 64'd8);
            if (flush) flushes++;
            if (k < 6) begin
                drive(I_BEQ, I_BEQ, 64'h4000, 64'h8, 64'h0);
            end else begin
                idle();
                redirect_ready = 1'b1;
            end
            tick();
        end
        if (flush) flushes++;
        chkb("jal_flush", flush, 1'b1);
        chkb("jal_rv_drop", redirect_valid, 1'b0);
        tick();
        if (flush) flushes++;
        chkb("jal_in_ready", in_ready, 1'b1);
        tick();
        if (flush) flushes++;
        chk("jal_flush_count", 64'(flushes), 64'd1);
        chk("jal_cnt_taken", cnt_taken, 64'd4);
        chk("jal_cnt_branch", cnt_branch, 64'd8);

        // in_valid with empty bj_info is ignored
        drive(8'h00, 8'hFF, 64'h999, 64'h8, 64'h0);
        tick();
        idle();
        chkb("none_link_valid", link_valid, 1'b0);
        chk("none_link_data", link_data, 64'h3004);
        chk("none_cnt_branch", cnt_branch, 64'd8);
        chk("none_cnt_taken", cnt_taken, 64'd4);
        chkb("none_rv", redirect_valid, 1'b0);
        chkb("none_exc", exc_misalign, 1'b0);
        chkb("none_in_ready", in_ready, 1'b1);

        // Taken counter wrap from all-ones
        @(negedge clk);
        force dut.u_cnt_taken.cnt_q = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clk);
        release dut.u_cnt_taken.cnt_q;
        #1;
        chk("wrap_preload", cnt_taken, 64'hFFFF_FFFF_FFFF_FFFF);
        tick();
        drive(I_JAL, D_JMP, 64'h5000, 64'h8, 64'h0);
        tick();
        idle();
        chk("wrap_cnt_taken", cnt_taken, 64'd0);
        chk("wrap_cnt_branch", cnt_branch, 64'd9);
        chk("wrap_rpc", redirect_pc, 64'h5008);
        tick();
        tick();
        chkb("wrap_in_ready", in_ready, 1'b1);

        // Asynchronous reset while a redirect is pending
        redirect_ready = 1'b0;
        drive(I_JAL, D_JMP, 64'h6000, 64'h40, 64'h0);
        tick();
        idle();
        chkb("areset_pre_rv", redirect_valid, 1'b1);
        chkb("areset_pre_link_valid", link_valid, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chkb("areset_rv", redirect_valid, 1'b0);
        chkb("areset_link_valid", link_valid, 1'b0);
        chk("areset_rpc", redirect_pc, 64'd0);
        chk("areset_cnt_branch", cnt_branch, 64'd0);
        chk("areset_cnt_taken", cnt_taken, 64'd0);
        chkb("areset_in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chkb("after_areset_in_ready", in_ready, 1'b1);
        chkb("after_areset_flush", flush, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/exe_stage_bju.md
# exe_stage_bju

Branch/jump resolution unit for the EXE stage. It consumes the one-hot branch-condition vector `bj_data` produced by the EXE ALU, decides taken/not-taken and computes the target. It then drives a held redirect request to the IF stage and, once the redirect is accepted, pulses a one-cycle flush of younger stages. It also produces the registered link value (pc+4), misaligned-target exceptions, and 64-bit branch statistics counters.

## Interface
Parameters:
- `RESET_PC_ALIGN`, default 2: required target alignment in bytes is 2^RESET_PC_ALIGN. No C extension, so only bit 1 is checked once bit 0 is cleared.

Ports (reset is asynchronous and active-high; clock `clk`, reset `rst`):
- `clk` in 1: clock.
- `rst` in 1: asynchronous active-high reset.
- `in_valid` in 1: branch/jump instruction present in EXE.
- `in_ready` out 1: unit can accept; combinational, equals state==IDLE.
- `pc` in 64: instruction PC.
- `imm` in 64: sign-extended immediate.
- `op1` in 64: rs1 value, used as the JALR base.
- `bj_info` in `BJ_BUS` (8): one-hot type from decode, indices `BJ_BEQ`..`BJ_JAL`.
- `bj_data` in `BJ_BUS` (8): condition vector from the ALU.
- `link_valid` out 1: registered pulse, link value ready.
- `link_data` out 64: registered pc+4.
- `redirect_valid` out 1: redirect request; held until accepted.
- `redirect_pc` out 64: target; stable while `redirect_valid` is high.
- `redirect_ready` in 1: IF accepts the redirect.
- `flush` out 1: one-cycle kill of the IF/ID stages.
- `exc_misalign` out 1: registered pulse, instruction-address-misaligned.
- `exc_tval` out 64: faulting target, valid with `exc_misalign`.
- `cnt_branch` out 64: accepted branch/jump count.
- `cnt_taken` out 64: taken count.

## Operation
- Accept occurs when `in_valid & in_ready & |bj_info`.
  - `in_valid` with `bj_info==0` is ignored: no outputs, no counting.
  - Multi-hot `bj_info` is illegal; decode guarantees one-hot.
- `taken = |(bj_info & bj_data)`. JAL and JALR bits in `bj_data` are always 1.
- Target:
  - JALR: `(op1+imm) & ~64'h1`.
  - Otherwise: `pc+imm`.
  - All arithmetic is modulo 2^64.
- On accept:
  - `link_data <= pc+4`; `link_valid` pulses for one cycle. This happens for every type; writeback ignores it for B-type.
  - `cnt_branch` increments.
  - If taken, `cnt_taken` increments. Counters wrap at 2^64 and never saturate.
- FSM states IDLE, REQ, FLUSH:
  - IDLE, accepted, not taken: stay in IDLE. No redirect.
  - IDLE, accepted, taken, `target[1]==1`: stay in IDLE. Pulse `exc_misalign` with `exc_tval=target`. No redirect and no flush; the trap path handles the flush.
  - IDLE, accepted, taken, aligned: go to REQ and latch `redirect_pc=target`.
  - REQ: `redirect_valid=1`. When `redirect_ready` is high, go to FLUSH.
  - FLUSH: `flush=1`, `redirect_valid=0`, then return to IDLE.
- `in_ready=0` in REQ and FLUSH. The EXE stage stalls, so no new instruction is accepted while a redirect is pending.
- Reset values: all outputs are 0, state is IDLE, counters are 0.
  - `in_ready` reads 1 during and after reset.
  - Reset asserted in REQ drops `redirect_valid` immediately (asynchronous).

## Timing
- Accept at the edge ending cycle N.
  - `link_valid`, `exc_misalign`, and counter updates are visible in cycle N+1.
  - `redirect_valid` is high from cycle N+1.
- `redirect_ready` is sampled at each edge while in REQ.
  - If it is high in cycle N+1, `flush` is high in cycle N+2.
  - `in_ready` is high again in N+3.
  - Minimum taken occupancy is 3 cycles; each extra cycle of `redirect_ready` low adds one.
- Not-taken branches, misaligned faults, and ignored inputs keep `in_ready=1`. Back-to-back accepts are allowed every cycle.
- `redirect_ready` high outside REQ has no effect.
- No combinational path from any input to any output except `in_ready`, which depends on state only.

## Structure
- `BJ_BUS` and `BJ_*` index macros come from the shared `defines.v`.
- Add `BJU_IDLE`, `BJU_REQ`, `BJU_FLUSH` state encodings (2-bit) to `defines.v`.
- Single module. One natural sub-module, `bju_counter64`: a 64-bit enable-increment counter with async reset, instantiated twice.

## Test plan
- BEQ taken: pc=0x8000_0000, imm=0x40, `bj_data[BJ_BEQ]=1`, `redirect_ready` tied 1.
  - `redirect_valid` high in N+1 with `redirect_pc=0x8000_0040`.
  - `flush` high in N+2; `in_ready` high in N+3.
  - `cnt_branch=1`, `cnt_taken=1`.
- BNE not taken on 4 consecutive cycles.
  - `in_ready` stays 1; no redirect or flush.
  - `cnt_branch=4`, `cnt_taken=0`.
  - `link_data=pc+4` each cycle.
- JALR: op1=0x8000_1003, imm=0. Target=0x8000_1002, bit1 set.
  - `exc_misalign` pulses with `exc_tval=0x8000_1002`; no redirect.
- JAL taken with `redirect_ready=0` for 5 cycles, then 1.
  - `redirect_valid` and `redirect_pc` are stable for 6 cycles.
  - A new `in_valid` during the wait is not accepted.
  - `flush` pulses exactly once.
- Assert `rst` while in REQ.
  - `redirect_valid`, counters, and `link_valid` go to 0 immediately.
  - `in_ready=1`.
- Preload/force `cnt_taken=64'hFFFF_FFFF_FFFF_FFFF`, then one taken JAL.
  - Counter wraps to 0.
- `in_valid=1` with `bj_info=0`.
  - No counters change; no outputs change.
